dcache_controller: RTL and testbench
====================================

# dcache_controller

Direct-mapped, write-back, write-allocate data cache between the single-cycle core's load/store path and a line-wide backing data memory. It presents a word interface to the core, replacing the zero-latency data memory. It asserts a combinational stall on a miss until the line is resident. A small FSM runs a request/acknowledge handshake with slow memory for dirty-victim write-back and line refill.

## Interface
Parameters:
- LINES, 32, number of cache lines; power of two, 2..256. Index width IW = log2(LINES).

Ports (name, direction, width, meaning):
- clk_i, in, 1, sole clock; all state updates on rising edge.
- rst_i, in, 1, reset: asynchronous, active-low.
- cpu_req_i, in, 1, core access this cycle (MemRead | MemWrite).
- cpu_we_i, in, 1, 1 = store, 0 = load.
- cpu_addr_i, in, 32, byte address; bits [1:0] ignored.
- cpu_data_i, in, 32, store data.
- cpu_data_o, out, 32, load data; valid on a read hit.
- cpu_stall_o, out, 1, core must freeze PC and hold all cpu_* inputs.
- mem_req_o, out, 1, memory transaction pending.
- mem_we_o, out, 1, 1 = line write-back, 0 = line fetch.
- mem_addr_o, out, 32, line-aligned address; bits [3:0] = 0.
- mem_data_o, out, 128, victim line for write-back.
- mem_data_i, in, 128, fetched line; sampled when mem_ack_i = 1.
- mem_ack_i, in, 1, one-cycle pulse; completes the current transaction.

## Operation
- Line: 4 words, 128 bits. Word w occupies bits [32w+31:32w], selected by addr[3:2].
- Index = addr[IW+3:4]. Tag = addr[31:IW+4].
- Per-line state: valid, dirty, tag, data.
- hit = cpu_req_i & valid[index] & (tag[index] == addr tag) & state == IDLE.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE
  - On a read hit, cpu_data_o returns the selected word combinationally.
  - On a write hit, the selected word is written and dirty is set at the clock edge.
  - On a miss with a valid, dirty victim, the next state is WRITEBACK.
  - On a miss otherwise, the next state is ALLOCATE.
- WRITEBACK
  - Outputs: mem_req_o = 1, mem_we_o = 1, mem_addr_o = {victim tag, index, 4'b0}, mem_data_o = victim line.
  - On mem_ack_i, the dirty bit clears and the next state is ALLOCATE.
- ALLOCATE
  - Outputs: mem_req_o = 1, mem_we_o = 0, mem_addr_o = {req tag, index, 4'b0}.
  - On mem_ack_i, the line is loaded from mem_data_i with valid = 1, dirty = 0 and the new tag, and the next state is IDLE.
- The retried access then hits in IDLE and completes normally. A store miss therefore sets dirty on the retry cycle.
- cpu_stall_o = cpu_req_i & ~hit, or state != IDLE.
- In IDLE:
  - mem_req_o, mem_we_o, mem_addr_o and mem_data_o are all 0.
  - cpu_data_o is 0 when no read hit.
- mem_ack_i in IDLE is ignored.
- If cpu_req_i drops mid-miss, the transaction still completes and the line is filled; no store is performed.
- Reset (async):
  - state goes to IDLE; all valid and dirty bits clear.
  - mem_req_o goes low immediately; an in-flight transaction is abandoned.
  - Tags and data are not reset.

## Timing
- Hit: zero added cycles. Load data is combinational in the same cycle; the store commits at the end of that cycle.
- Clean miss, request in cycle 0:
  - ALLOCATE from cycle 1; mem_req_o is high from cycle 1.
  - Ack in cycle k fills the line at the end of k.
  - Cycle k+1 is the hit cycle: stall low and access completes.
- Dirty miss: WRITEBACK runs from cycle 1 until its ack, then ALLOCATE starts the next cycle.
  - mem_req_o stays high across the switch; mem_we_o and mem_addr_o change.
  - Each mem_ack_i retires exactly one transaction.
- mem_addr_o, mem_we_o and mem_data_o are stable for every cycle mem_req_o is high within one transaction.
- All outputs are combinational from state, line arrays and cpu_* inputs. There is no path from mem_ack_i to any output in the same cycle.

## Test plan
LINES = 32, so index = addr[8:4] and tag = addr[31:9].
1. After reset, load 0x00000040.
   - Required: stall = 1; ALLOCATE with mem_addr_o = 0x40, mem_we_o = 0.
   - Ack with the line w0 = 0x11111111, w1 = 0x22222222, w2 = 0x33333333, w3 = 0x44444444.
   - Required next cycle: stall = 0, cpu_data_o = 0x11111111.
   - Then load 0x44: 0x22222222 with no mem_req_o.
2. Store 0xDEADBEEF to 0x48.
   - Required: no stall.
   - Load 0x48: 0xDEADBEEF.
   - Line 4 is now dirty.
3. Load 0x00000240 (index 4, tag 1).
   - Required: WRITEBACK with mem_addr_o = 0x40, mem_we_o = 1, mem_data_o[95:64] = 0xDEADBEEF.
   - After ack: ALLOCATE with mem_addr_o = 0x240, mem_we_o = 0.
   - After second ack: load completes one cycle later.
4. Delay mem_ack_i by 5 cycles.
   - Required: mem_req_o, mem_addr_o and stall constant for all 5 cycles.
   - Stall drops exactly one cycle after the ack.
5. Store miss 0xA5A5A5A5 to 0x00001000 (clean victim).
   - Required: ALLOCATE only, no WRITEBACK.
   - Retry writes the word and sets dirty.
   - A later conflicting miss to 0x00001200 (index 0, tag 9) write-backs address 0x1000 with w0 = 0xA5A5A5A5.
6. Assert rst_i low during ALLOCATE.
   - Required: mem_req_o = 0 and state IDLE immediately.
   - After release, load 0x240 misses again.

Source files
------------

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache sitting between the core's
// word-wide load/store port and a slow line-wide memory with a req/ack handshake.
module dcache_controller #(
   parameter int LINES = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         cpu_req_i,
   input  logic         cpu_we_i,
   input  logic [31:0]  cpu_addr_i,
   input  logic [31:0]  cpu_data_i,
   output logic [31:0]  cpu_data_o,
   output logic         cpu_stall_o,
   output logic         mem_req_o,
   output logic         mem_we_o,
   output logic [31:0]  mem_addr_o,
   output logic [127:0] mem_data_o,
   input  logic [127:0] mem_data_i,
   input  logic         mem_ack_i
);

   localparam int IW = $clog2(LINES);
   localparam int TW = 32 - IW - 4;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2
   } state_t;

   state_t          state_r;
   state_t          state_s;
   logic [LINES-1:0] valid_r;
   logic [LINES-1:0] dirty_r;
   logic [TW-1:0]   tag_r  [LINES];
   logic [127:0]    data_r [LINES];
   // Miss index/tag are captured so the transaction survives cpu_req_i dropping.
   logic [IW-1:0]   miss_idx_r;
   logic [TW-1:0]   miss_tag_r;

   logic [IW-1:0]   req_idx_s;
   logic [TW-1:0]   req_tag_s;
   logic [1:0]      word_s;
   logic            hit_s;
   logic            unused_s;

   assign req_idx_s = cpu_addr_i[IW+3:4];
   assign req_tag_s = cpu_addr_i[31:IW+4];
   assign word_s    = cpu_addr_i[3:2];
   assign unused_s  = ^cpu_addr_i[1:0];

   // Hit detection, next-state logic and all combinational outputs.
   always_comb begin
      hit_s       = cpu_req_i & valid_r[req_idx_s] & (tag_r[req_idx_s] == req_tag_s)
                    & (state_r == IDLE);
      state_s     = state_r;
      cpu_data_o  = 32'd0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = 32'd0;
      mem_data_o  = 128'd0;
      case (state_r)
         IDLE: begin
            if (cpu_req_i && !hit_s) begin
               if (valid_r[req_idx_s] && dirty_r[req_idx_s]) begin
                  state_s = WRITEBACK;
               end else begin
                  state_s = ALLOCATE;
               end
            end else if (hit_s && !cpu_we_i) begin
               cpu_data_o = data_r[req_idx_s][{word_s, 5'd0} +: 32];
            end else begin
               state_s = IDLE;
            end
         end
         WRITEBACK: begin
            mem_req_o  = 1'b1;
            mem_we_o   = 1'b1;
            mem_addr_o = {tag_r[miss_idx_r], miss_idx_r, 4'b0000};
            mem_data_o = data_r[miss_idx_r];
            if (mem_ack_i) begin
               state_s = ALLOCATE;
            end else begin
               state_s = WRITEBACK;
            end
         end
         ALLOCATE: begin
            mem_req_o  = 1'b1;
            mem_we_o   = 1'b0;
            mem_addr_o = {miss_tag_r, miss_idx_r, 4'b0000};
            if (mem_ack_i) begin
               state_s = IDLE;
            end else begin
               state_s = ALLOCATE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
      cpu_stall_o = (cpu_req_i & ~hit_s) | (state_r != IDLE);
   end

   // FSM state, miss capture and valid/dirty bookkeeping.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_r    <= IDLE;
         valid_r    <= '0;
         dirty_r    <= '0;
         miss_idx_r <= '0;
         miss_tag_r <= '0;
      end else begin
         state_r <= state_s;
         if (state_r == IDLE && cpu_req_i && !hit_s) begin
            miss_idx_r <= req_idx_s;
            miss_tag_r <= req_tag_s;
         end
         if (hit_s && cpu_we_i) begin
            dirty_r[req_idx_s] <= 1'b1;
         end
         if (state_r == WRITEBACK && mem_ack_i) begin
            dirty_r[miss_idx_r] <= 1'b0;
         end
         if (state_r == ALLOCATE && mem_ack_i) begin
            valid_r[miss_idx_r] <= 1'b1;
            dirty_r[miss_idx_r] <= 1'b0;
         end
      end
   end

   // Tag and data arrays; store hits and refills never coincide (IDLE vs ALLOCATE).
   always_ff @(posedge clk_i) begin
      if (hit_s && cpu_we_i) begin
         data_r[req_idx_s][{word_s, 5'd0} +: 32] <= cpu_data_i;
      end else if (state_r == ALLOCATE && mem_ack_i) begin
         data_r[miss_idx_r] <= mem_data_i;
         tag_r[miss_idx_r]  <= miss_tag_r;
      end
   end

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: scoreboarded loads against a flat
// memory model, plus a backing-memory responder that logs every line transaction.
module tb_dcache_controller;

   localparam int BUDGET = 40;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         cpu_req_i;
   logic         cpu_we_i;
   logic [31:0]  cpu_addr_i;
   logic [31:0]  cpu_data_i;
   logic [31:0]  cpu_data_o;
   logic         cpu_stall_o;
   logic         mem_req_o;
   logic         mem_we_o;
   logic [31:0]  mem_addr_o;
   logic [127:0] mem_data_o;
   logic [127:0] mem_data_i;
   logic         mem_ack_i;

   typedef struct {
      logic         we;
      logic [31:0]  addr;
      logic [127:0] data;
   } txn_t;

   int           n_tests = 0;
   int           n_fail  = 0;
   int           ack_delay = 0;
   int           sc;
   txn_t         txn_q[$];
   logic [31:0]  exp_q[$];
   logic [127:0] mem_model[logic [31:0]];
   logic [31:0]  ref_mem[logic [31:0]];

   dcache_controller #(.LINES(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
      .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return {a[31:2], 2'b00} ^ 32'hC0DE_0000;
   endfunction

   function automatic logic [127:0] backing_line(input logic [31:0] la);
      if (mem_model.exists(la)) return mem_model[la];
      return {init_word(la + 32'd12), init_word(la + 32'd8), init_word(la + 32'd4), init_word(la)};
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      logic [31:0] wa;
      wa = {a[31:2], 2'b00};
      if (ref_mem.exists(wa)) return ref_mem[wa];
      return init_word(wa);
   endfunction

   // Backing memory: acks after ack_delay idle request cycles, logs each transaction.
   initial begin
      int cnt;
      cnt = 0;
      mem_ack_i  = 1'b0;
      mem_data_i = 128'd0;
      forever begin
         @(negedge clk_i);
         #2;
         if (!rst_i || !mem_req_o) begin
            mem_ack_i = 1'b0;
            cnt = 0;
         end else if (cnt >= ack_delay) begin
            mem_ack_i = 1'b1;
            cnt = 0;
            if (mem_we_o) begin
               txn_q.push_back('{1'b1, mem_addr_o, mem_data_o});
               mem_model[mem_addr_o] = mem_data_o;
            end else begin
               mem_data_i = backing_line(mem_addr_o);
               txn_q.push_back('{1'b0, mem_addr_o, mem_data_i});
            end
         end else begin
            mem_ack_i = 1'b0;
            cnt++;
         end
      end
   end

   task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         output int stall_cycles);
      logic [31:0] exp;
      @(negedge clk_i);
      cpu_req_i  = 1'b1;
      cpu_we_i   = we;
      cpu_addr_i = addr;
      cpu_data_i = wdata;
      if (we) ref_mem[{addr[31:2], 2'b00}] = wdata;
      else exp_q.push_back(ref_read(addr));
      stall_cycles = 0;
      #1;
      while (cpu_stall_o !== 1'b0 && stall_cycles < BUDGET) begin
         @(negedge clk_i);
         #1;
         stall_cycles++;
      end
      n_tests++;
      if (cpu_stall_o !== 1'b0) begin
         n_fail++;
         $display("FAIL access_timeout addr=%h stall=%b after %0d cycles, required 0", addr, cpu_stall_o, stall_cycles);
         if (!we) exp = exp_q.pop_front();
      end else if (!we) begin
         exp = exp_q.pop_front();
         if (cpu_data_o !== exp) begin
            n_fail++;
            $display("FAIL load_data addr=%h got %h required %h", addr, cpu_data_o, exp);
         end
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = 32'd0; cpu_data_i = 32'd0;
      repeat (2) @(negedge clk_i);
      #1;
      n_tests++;
      if ({mem_req_o, mem_we_o, mem_addr_o, cpu_stall_o, cpu_data_o} !== 67'd0) begin
         n_fail++;
         $display("FAIL reset_outputs req=%b we=%b addr=%h stall=%b data=%h required all 0",
                  mem_req_o, mem_we_o, mem_addr_o, cpu_stall_o, cpu_data_o);
      end
      @(negedge clk_i);
      rst_i = 1'b1;
   endtask

   task automatic test_clean_miss();
      txn_q.delete();
      access(1'b0, 32'h0000_0040, 32'd0, sc);
      n_tests++;
      if (sc !== 2) begin n_fail++; $display("FAIL miss_latency got %0d stall cycles required 2", sc); end
      n_tests++;
      if (txn_q.size() != 1) begin
         n_fail++; $display("FAIL miss_txn_count got %0d required 1", txn_q.size());
      end else if (txn_q[0].we !== 1'b0 || txn_q[0].addr !== 32'h40) begin
         n_fail++; $display("FAIL miss_alloc got we=%b addr=%h required we=0 addr=00000040", txn_q[0].we, txn_q[0].addr);
      end
      txn_q.delete();
      access(1'b0, 32'h0000_0044, 32'd0, sc);
      n_tests++;
      if (sc !== 0 || txn_q.size() != 0) begin
         n_fail++; $display("FAIL hit_no_mem got stall=%0d txns=%0d required 0 0", sc, txn_q.size());
      end
   endtask

   task automatic test_back_to_back();
      access(1'b1, 32'h0000_0048, 32'hDEAD_BEEF, sc);
      n_tests++;
      if (sc !== 0) begin n_fail++; $display("FAIL store_hit_stall got %0d required 0", sc); end
      access(1'b0, 32'h0000_0048, 32'd0, sc);
      n_tests++;
      if (sc !== 0) begin n_fail++; $display("FAIL load_after_store_stall got %0d required 0", sc); end
   endtask

   task automatic test_dirty_miss();
      txn_q.delete();
      access(1'b0, 32'h0000_0240, 32'd0, sc);
      n_tests++;
      if (sc !== 3) begin n_fail++; $display("FAIL dirty_latency got %0d required 3", sc); end
      n_tests++;
      if (txn_q.size() != 2) begin
         n_fail++; $display("FAIL dirty_txn_count got %0d required 2", txn_q.size());
      end else begin
         if (txn_q[0].we !== 1'b1 || txn_q[0].addr !== 32'h40 ||
             txn_q[0].data[95:64] !== 32'hDEAD_BEEF || txn_q[0].data[31:0] !== 32'h1111_1111) begin
            n_fail++;
            $display("FAIL writeback got we=%b addr=%h data=%h required we=1 addr=00000040 w2=deadbeef w0=11111111",
                     txn_q[0].we, txn_q[0].addr, txn_q[0].data);
         end
         n_tests++;
         if (txn_q[1].we !== 1'b0 || txn_q[1].addr !== 32'h240) begin
            n_fail++; $display("FAIL refill got we=%b addr=%h required we=0 addr=00000240", txn_q[1].we, txn_q[1].addr);
         end
      end
   endtask

   task automatic test_ack_delay();
      logic [31:0] exp;
      ack_delay = 5;
      @(negedge clk_i);
      cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0080;
      exp_q.push_back(ref_read(32'h80));
      #1;
      n_tests++;
      if (cpu_stall_o !== 1'b1 || mem_req_o !== 1'b0) begin
         n_fail++; $display("FAIL delay_cycle0 got stall=%b req=%b required 1 0", cpu_stall_o, mem_req_o);
      end
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk_i);
         #1;
         n_tests++;
         if ({cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o} !== {1'b1, 1'b1, 1'b0, 32'h0000_0080}) begin
            n_fail++;
            $display("FAIL delay_hold cycle %0d got stall=%b req=%b we=%b addr=%h required 1 1 0 00000080",
                     i, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o);
         end
      end
      @(negedge clk_i);
      #1;
      exp = exp_q.pop_front();
      n_tests++;
      if (cpu_stall_o !== 1'b0 || cpu_data_o !== exp) begin
         n_fail++; $display("FAIL delay_release got stall=%b data=%h required 0 %h", cpu_stall_o, cpu_data_o, exp);
      end
      ack_delay = 0;
   endtask

   task automatic test_store_miss();
      txn_q.delete();
      access(1'b1, 32'h0000_1000, 32'hA5A5_A5A5, sc);
      n_tests++;
      if (sc !== 2 || txn_q.size() != 1) begin
         n_fail++; $display("FAIL store_miss got stall=%0d txns=%0d required 2 1", sc, txn_q.size());
      end else if (txn_q[0].we !== 1'b0 || txn_q[0].addr !== 32'h1000) begin
         n_fail++; $display("FAIL store_miss_alloc got we=%b addr=%h required we=0 addr=00001000", txn_q[0].we, txn_q[0].addr);
      end
      txn_q.delete();
      access(1'b0, 32'h0000_1200, 32'd0, sc);
      n_tests++;
      if (sc !== 3 || txn_q.size() != 2) begin
         n_fail++; $display("FAIL conflict_miss got stall=%0d txns=%0d required 3 2", sc, txn_q.size());
      end else if (txn_q[0].we !== 1'b1 || txn_q[0].addr !== 32'h1000 || txn_q[0].data[31:0] !== 32'hA5A5_A5A5 ||
                   txn_q[1].we !== 1'b0 || txn_q[1].addr !== 32'h1200) begin
         n_fail++;
         $display("FAIL conflict_txns got wb(we=%b addr=%h w0=%h) fill(we=%b addr=%h) required 1 00001000 a5a5a5a5 0 00001200",
                  txn_q[0].we, txn_q[0].addr, txn_q[0].data[31:0], txn_q[1].we, txn_q[1].addr);
      end
      access(1'b0, 32'h0000_1000, 32'd0, sc);
   endtask

   task automatic test_reset_mid_alloc();
      ack_delay = 3;
      @(negedge clk_i);
      cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_3000;
      @(negedge clk_i);
      #1;
      n_tests++;
      if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 32'h3000) begin
         n_fail++; $display("FAIL pre_reset_alloc got req=%b we=%b addr=%h required 1 0 00003000", mem_req_o, mem_we_o, mem_addr_o);
      end
      @(negedge clk_i);
      cpu_req_i = 1'b0;
      rst_i = 1'b0;
      #1;
      n_tests++;
      if ({mem_req_o, mem_we_o, mem_addr_o, cpu_stall_o} !== 35'd0) begin
         n_fail++; $display("FAIL reset_abort got req=%b we=%b addr=%h stall=%b required all 0",
                            mem_req_o, mem_we_o, mem_addr_o, cpu_stall_o);
      end
      @(negedge clk_i);
      rst_i = 1'b1;
      ack_delay = 0;
      txn_q.delete();
      access(1'b0, 32'h0000_0240, 32'd0, sc);
      n_tests++;
      if (sc !== 2 || txn_q.size() != 1) begin
         n_fail++; $display("FAIL post_reset_miss got stall=%0d txns=%0d required 2 1", sc, txn_q.size());
      end
   endtask

   initial begin
      mem_model[32'h40] = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      ref_mem[32'h40] = 32'h1111_1111;
      ref_mem[32'h44] = 32'h2222_2222;
      ref_mem[32'h48] = 32'h3333_3333;
      ref_mem[32'h4C] = 32'h4444_4444;
      test_reset();
      test_clean_miss();
      test_back_to_back();
      test_dirty_miss();
      test_ack_delay();
      test_store_miss();
      test_reset_mid_alloc();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
